// File: rtl/fft_pkg.sv
// Shared FFT datapath types, twiddle constants and fixed-point helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package fft_pkg;

    // Default complex sample width used by the FFT datapath (Q1.15).
    localparam int CPLX_W = 16;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    // Radix-4 twiddles: W^0 = 1, W^1 = -j, W^2 = -1 (Q1.15, -1 is exact, +1 is 1-2^-15).
    localparam cplx_t W0_4 = '{re: 16'sh7FFF, im: 16'sh0000};
    localparam cplx_t W1_4 = '{re: 16'sh0000, im: 16'sh8000};
    localparam cplx_t W2_4 = '{re: 16'sh8000, im: 16'sh0000};

    // Wide signed scratch type; comfortably holds any product or radix-4 sum.
    localparam int ACC_W = 64;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Round half up, then arithmetic shift right by sh; sh == 0 passes through.
    function automatic acc_t round_shift(input acc_t x, input int sh);
        acc_t r;
        if (sh <= 0) begin
            r = x;
        end else begin
            r = (x + (acc_t'(1) <<< (sh - 1))) >>> sh;
        end
        return r;
    endfunction

    // x + y clipped to a signed w-bit range; ovf reports that clipping happened.
    function automatic acc_t sat_add(input acc_t x, input acc_t y, input int w, output logic ovf);
        acc_t s;
        acc_t hi;
        acc_t lo;
        s   = x + y;
        hi  = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
        lo  = -hi - acc_t'(1);
        ovf = 1'b0;
        if (s > hi) begin
            s   = hi;
            ovf = 1'b1;
        end else if (s < lo) begin
            s   = lo;
            ovf = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/butterfly_4_pipe_if.sv
// Streaming bundle for the radix-4 butterfly: input beat, output beat, saturation status.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the input and output sides.
interface butterfly_4_pipe_if #(
    parameter int FULL_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [FULL_WIDTH-1:0] a, b, c, d;
    logic [FULL_WIDTH-1:0] w0, w1, w2, w3;
    logic                  inverse;
    logic [1:0]            scale_sh;
    logic                  out_valid;
    logic                  out_ready;
    logic [FULL_WIDTH-1:0] out0, out1, out2, out3;
    logic                  sat;
    logic                  sat_clr;

    modport master (
        output in_valid, a, b, c, d, w0, w1, w2, w3, inverse, scale_sh, out_ready, sat_clr,
        input  in_ready, out_valid, out0, out1, out2, out3, sat
    );

    modport slave (
        input  in_valid, a, b, c, d, w0, w1, w2, w3, inverse, scale_sh, out_ready, sat_clr,
        output in_ready, out_valid, out0, out1, out2, out3, sat
    );
endinterface

// File: rtl/cmul_q15.sv
// Complex multiply by a Q1.(WIDTH-1) twiddle, then round half up and saturate to WIDTH.
// Latency: 2 register stages (product register, rounded result register).
// Backpressure: stage loads are gated by en1/en2 supplied by the parent pipeline.
module cmul_q15
    import fft_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FULL_WIDTH = 2 * WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en1,
    input  logic                  en2,
    input  logic [FULL_WIDTH-1:0] x,
    input  logic [FULL_WIDTH-1:0] w,
    output logic [FULL_WIDTH-1:0] y,
    output logic                  ovf
);
    localparam int PW = 2 * WIDTH + 1;

    logic signed [WIDTH-1:0] xr, xi, wr, wi;
    logic signed [PW-1:0]    p_re_d, p_im_d;
    logic signed [PW-1:0]    p_re_q, p_im_q;
    acc_t                    rnd_re, rnd_im;
    logic [WIDTH-1:0]        y_re_d, y_im_d;
    logic                    ovf_re, ovf_im;

    assign xr = x[FULL_WIDTH-1:WIDTH];
    assign xi = x[WIDTH-1:0];
    assign wr = w[FULL_WIDTH-1:WIDTH];
    assign wi = w[WIDTH-1:0];

    // Full-precision products; operands sign-extended so nothing wraps.
    assign p_re_d = PW'(xr) * PW'(wr) - PW'(xi) * PW'(wi);
    assign p_im_d = PW'(xr) * PW'(wi) + PW'(xi) * PW'(wr);

    // Stage 1: capture the raw complex product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_re_q <= '0;
            p_im_q <= '0;
        end else if (en1) begin
            p_re_q <= p_re_d;
            p_im_q <= p_im_d;
        end
    end

    // Drop the Q1.(WIDTH-1) fraction with round-half-up and clip back to WIDTH bits.
    always_comb begin
        ovf_re = 1'b0;
        ovf_im = 1'b0;
        rnd_re = round_shift(acc_t'(p_re_q), WIDTH - 1);
        rnd_im = round_shift(acc_t'(p_im_q), WIDTH - 1);
        y_re_d = WIDTH'(sat_add(rnd_re, '0, WIDTH, ovf_re));
        y_im_d = WIDTH'(sat_add(rnd_im, '0, WIDTH, ovf_im));
    end

    // Saturation of the product now sitting in stage 1; parent qualifies it with the advance.
    assign ovf = ovf_re | ovf_im;

    // Stage 2: capture the rounded, saturated product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y <= '0;
        end else if (en2) begin
            y <= {y_re_d, y_im_d};
        end
    end
endmodule

// File: rtl/butterfly_4_pipe.sv
// Pipelined radix-4 DIT butterfly with twiddle multiply, per-beat direction/scale and sticky sat.
// Latency: 3 cycles accept-to-out_valid, 1 beat/cycle throughput.
// Backpressure: each stage loads when empty or when the next stage moves; full stall holds 3 beats.
module butterfly_4_pipe
    import fft_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FULL_WIDTH = 2 * WIDTH,
    parameter int MAX_SHIFT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    butterfly_4_pipe_if.slave  bus
);
    logic                  v1, v2, v3;
    logic                  ready1, ready2, ready3;
    logic                  en1, en2, en3;
    logic                  inv1, inv2;
    logic [1:0]            sh_in, sh1, sh2;
    logic [FULL_WIDTH-1:0] xin [4];
    logic [FULL_WIDTH-1:0] win [4];
    logic [FULL_WIDTH-1:0] yb  [4];
    logic [3:0]            ovf2;
    acc_t                  ar, ai, br, bi, cr, ci, dr, di;
    acc_t                  u_re, u_im, t_re, t_im;
    acc_t                  xs  [8];
    logic [WIDTH-1:0]      os  [8];
    logic                  f, ovf3_any;
    logic                  sat_set, sat_q;
    logic [FULL_WIDTH-1:0] out_q [4];

    // Ready chain: a stage can take a beat if it is empty or its contents move on.
    assign ready3 = !v3 || bus.out_ready;
    assign ready2 = !v2 || ready3;
    assign ready1 = !v1 || ready2;
    assign en1    = bus.in_valid && ready1;
    assign en2    = v1 && ready2;
    assign en3    = v2 && ready3;

    assign bus.in_ready  = ready1;
    assign bus.out_valid = v3;
    assign bus.out0      = out_q[0];
    assign bus.out1      = out_q[1];
    assign bus.out2      = out_q[2];
    assign bus.out3      = out_q[3];
    assign bus.sat       = sat_q;

    // Out-of-range shift requests are clamped before they enter the pipe.
    assign sh_in = (int'(bus.scale_sh) > MAX_SHIFT) ? 2'(MAX_SHIFT) : bus.scale_sh;

    assign xin[0] = bus.a;
    assign xin[1] = bus.b;
    assign xin[2] = bus.c;
    assign xin[3] = bus.d;
    assign win[0] = bus.w0;
    assign win[1] = bus.w1;
    assign win[2] = bus.w2;
    assign win[3] = bus.w3;

    for (genvar i = 0; i < 4; i++) begin : g_cmul
        cmul_q15 #(
            .WIDTH      (WIDTH),
            .FULL_WIDTH (FULL_WIDTH)
        ) u_cmul (
            .clk (clk),
            .rst (rst),
            .en1 (en1),
            .en2 (en2),
            .x   (xin[i]),
            .w   (win[i]),
            .y   (yb[i]),
            .ovf (ovf2[i])
        );
    end

    // Stage valid bits advance along the ready chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (ready1) v1 <= bus.in_valid;
            if (ready2) v2 <= v1;
            if (ready3) v3 <= v2;
        end
    end

    // Direction and scale travel with their beat alongside the multiplier stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv1 <= 1'b0;
            sh1  <= '0;
            inv2 <= 1'b0;
            sh2  <= '0;
        end else begin
            if (en1) begin
                inv1 <= bus.inverse;
                sh1  <= sh_in;
            end
            if (en2) begin
                inv2 <= inv1;
                sh2  <= sh1;
            end
        end
    end

    // Radix-4 combine, output scaling and saturation on the stage-2 products.
    always_comb begin
        ar = acc_t'($signed(yb[0][FULL_WIDTH-1:WIDTH]));
        ai = acc_t'($signed(yb[0][WIDTH-1:0]));
        br = acc_t'($signed(yb[1][FULL_WIDTH-1:WIDTH]));
        bi = acc_t'($signed(yb[1][WIDTH-1:0]));
        cr = acc_t'($signed(yb[2][FULL_WIDTH-1:WIDTH]));
        ci = acc_t'($signed(yb[2][WIDTH-1:0]));
        dr = acc_t'($signed(yb[3][FULL_WIDTH-1:WIDTH]));
        di = acc_t'($signed(yb[3][WIDTH-1:0]));
        // u = A - C, t = jB - jD, with j(r,i) = (-i,r).
        u_re  = ar - cr;
        u_im  = ai - ci;
        t_re  = di - bi;
        t_im  = br - dr;
        xs[0] = ar + br + cr + dr;
        xs[1] = ai + bi + ci + di;
        xs[4] = ar - br + cr - dr;
        xs[5] = ai - bi + ci - di;
        if (!inv2) begin
            xs[2] = u_re - t_re;
            xs[3] = u_im - t_im;
            xs[6] = u_re + t_re;
            xs[7] = u_im + t_im;
        end else begin
            xs[2] = u_re + t_re;
            xs[3] = u_im + t_im;
            xs[6] = u_re - t_re;
            xs[7] = u_im - t_im;
        end
        f        = 1'b0;
        ovf3_any = 1'b0;
        for (int k = 0; k < 8; k++) begin
            os[k]    = WIDTH'(sat_add(round_shift(xs[k], int'(sh2)), '0, WIDTH, f));
            ovf3_any = ovf3_any | f;
        end
    end

    // Stage 3: register the finished outputs; they hold while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) out_q[k] <= '0;
        end else if (en3) begin
            for (int k = 0; k < 4; k++) out_q[k] <= {os[2*k], os[2*k+1]};
        end
    end

    // Only beats actually advancing may raise the flag.
    assign sat_set = (en2 && (|ovf2)) || (en3 && ovf3_any);

    // Sticky saturation flag; a new event beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= (sat_q && !bus.sat_clr) || sat_set;
        end
    end
endmodule

// File: tb/tb_butterfly_4_pipe.sv
// Directed scoreboard bench for butterfly_4_pipe.
// Latency: checks 3-cycle accept-to-output and in-order delivery.
// Backpressure: exercises full stall, simultaneous retire/accept and mid-stream reset.
module tb_butterfly_4_pipe;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    butterfly_4_pipe_if #(.FULL_WIDTH(32)) bus ();

    butterfly_4_pipe #(
        .WIDTH      (16),
        .FULL_WIDTH (32),
        .MAX_SHIFT  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           n_pass   = 0;
    int           n_total  = 0;
    int           accepted = 0;
    logic [127:0] sb [$];
    logic [127:0] pending;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] cx(input int re, input int im);
        return {16'(re), 16'(im)};
    endfunction

    // Reference for real-only inputs with unity twiddle and no scaling.
    function automatic logic [127:0] ref_real(input int a, input int b, input int c, input int d,
                                              input logic inv);
        logic [31:0] x1, x3;
        x1 = inv ? cx(a - c, b - d) : cx(a - c, d - b);
        x3 = inv ? cx(a - c, d - b) : cx(a - c, b - d);
        return {cx(a + b + c + d, 0), x1, cx(a - b + c - d, 0), x3};
    endfunction

    task automatic set_beat(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input logic [31:0] d, input logic [31:0] w0, input logic [31:0] w1,
                            input logic inv, input int sh);
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
        bus.d        = d;
        bus.w0       = w0;
        bus.w1       = w1;
        bus.w2       = W0_4;
        bus.w3       = W0_4;
        bus.inverse  = inv;
        bus.scale_sh = 2'(sh);
    endtask

    // One clock: retire/compare, then accept/push, sampled mid-cycle; returns at next negedge.
    task automatic step();
        logic [127:0] e;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'(bus.out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("out0", bus.out0, e[127:96]);
                chk("out1", bus.out1, e[95:64]);
                chk("out2", bus.out2, e[63:32]);
                chk("out3", bus.out3, e[31:0]);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            accepted++;
            sb.push_back(pending);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic send(input logic [127:0] exp);
        pending      = exp;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        drain();
    endtask

    initial begin
        logic [31:0] hold;
        int          lat;
        int          k;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.sat_clr  = 1'b0;
        pending      = '0;
        set_beat('0, '0, '0, '0, W0_4, W0_4, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sat", 32'(bus.sat), 32'd0);
        chk("rst_out0", bus.out0, 32'd0);
        chk("rst_out3", bus.out3, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // Forward, scale 0, unity twiddles, with latency measurement.
        set_beat(cx(100, 0), cx(150, 0), cx(200, 0), cx(250, 0), W0_4, W0_4, 1'b0, 0);
        pending      = ref_real(100, 150, 200, 250, 1'b0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        drain();
        chk("fwd_sat", 32'(bus.sat), 32'd0);

        // Inverse, same data.
        set_beat(cx(100, 0), cx(150, 0), cx(200, 0), cx(250, 0), W0_4, W0_4, 1'b1, 0);
        send(ref_real(100, 150, 200, 250, 1'b1));

        // -j twiddle on b only.
        set_beat(cx(0, 0), cx(150, 0), cx(0, 0), cx(0, 0), W0_4, W1_4, 1'b0, 0);
        send({cx(0, -150), cx(-150, 0), cx(0, 150), cx(150, 0)});

        // Output saturation, then scaling, then clamp of an oversize shift.
        set_beat(cx(32767, 0), cx(32767, 0), cx(32767, 0), cx(32767, 0), W0_4, W0_4, 1'b0, 0);
        send({cx(32767, 0), cx(0, 0), cx(0, 0), cx(0, 0)});
        chk("sat_stage3", 32'(bus.sat), 32'd1);
        set_beat(cx(32767, 0), cx(32767, 0), cx(32767, 0), cx(32767, 0), W0_4, W0_4, 1'b0, 2);
        send({cx(32766, 0), cx(0, 0), cx(0, 0), cx(0, 0)});
        set_beat(cx(32767, 0), cx(32767, 0), cx(32767, 0), cx(32767, 0), W0_4, W0_4, 1'b0, 3);
        send({cx(32766, 0), cx(0, 0), cx(0, 0), cx(0, 0)});
        bus.sat_clr = 1'b1;
        step();
        bus.sat_clr = 1'b0;
        chk("sat_clr", 32'(bus.sat), 32'd0);

        // Product saturation: -1 * -1 in Q1.15.
        set_beat(cx(-32768, 0), cx(0, 0), cx(0, 0), cx(0, 0), W2_4, W0_4, 1'b0, 0);
        send({cx(32767, 0), cx(32767, 0), cx(32767, 0), cx(32767, 0)});
        chk("sat_stage2", 32'(bus.sat), 32'd1);

        // Full stall: 4 offered, 3 accepted, outputs held.
        bus.out_ready = 1'b0;
        accepted      = 0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            k       = accepted;
            pending = ref_real(10 + k, 20, 30, 40 + k, 1'b0);
            set_beat(cx(10 + k, 0), cx(20, 0), cx(30, 0), cx(40 + k, 0), W0_4, W0_4, 1'b0, 0);
            step();
        end
        chk("bp_accepted", 32'(accepted), 32'd3);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        hold = bus.out0;
        step();
        step();
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold_out0", bus.out0, hold);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_full_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        drain();
        chk("bp_total", 32'(accepted), 32'd4);

        // Reset with two beats in flight.
        set_beat(cx(1, 0), cx(2, 0), cx(3, 0), cx(4, 0), W0_4, W0_4, 1'b0, 0);
        pending      = ref_real(1, 2, 3, 4, 1'b0);
        bus.in_valid = 1'b1;
        step();
        set_beat(cx(5, 0), cx(6, 0), cx(7, 0), cx(8, 0), W0_4, W0_4, 1'b0, 0);
        pending = ref_real(5, 6, 7, 8, 1'b0);
        step();
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_sat", 32'(bus.sat), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        set_beat(cx(300, 0), cx(-50, 0), cx(20, 0), cx(-7, 0), W0_4, W0_4, 1'b0, 0);
        send(ref_real(300, -50, 20, -7, 1'b0));
        repeat (4) step();
        chk("post_rst_idle", 32'(bus.out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/butterfly_4_pipe.md
Name: butterfly_4_pipe

Overview:
- Pipelined, parametrised radix-4 DIT butterfly for the FFT datapath.
- Successor to the combinational butterfly_4. Adds:
  - per-input twiddle multiply with round/saturate;
  - valid/ready streaming with bubble collapse;
  - per-beat forward/inverse mode and output scaling;
  - a sticky saturation flag.
- Sits between the FFT sample-reorder buffer and the stage memory; one butterfly per beat.

Parameters:
- WIDTH, 16, bits per real/imag component (signed, Q1.(WIDTH-1) for twiddles).
- FULL_WIDTH, 2*WIDTH, packed complex word width; {re[FULL_WIDTH-1:WIDTH], im[WIDTH-1:0]}.
- MAX_SHIFT, 2, largest permitted scale_sh value.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a, b, c, d  in  FULL_WIDTH each  packed complex inputs.
- w0, w1, w2, w3  in  FULL_WIDTH each  packed Q1.15 twiddles for a..d.
- inverse  in  1  0 = forward (-j), 1 = inverse (+j); sampled with the beat.
- scale_sh  in  2  arithmetic right shift applied to outputs, 0..MAX_SHIFT; sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out0, out1, out2, out3  out  FULL_WIDTH each  packed complex results.
- sat  out  1  sticky: any saturation since reset or sat_clr.
- sat_clr  in  1  synchronous clear of sat.

Behaviour:
- Reset (async, rst=1):
  - all stage valid bits 0; out_valid=0; sat=0;
  - out0..out3 = 0; in_ready=1 once rst is low.
- Handshake:
  - A beat transfers on in_valid && in_ready. The output beat retires on out_valid && out_ready.
  - Payload and out_valid stay stable while out_valid && !out_ready.
- Pipeline: 3 stages, valid bits v1..v3.
  - Stage k loads when ready_k = !v_k || ready_{k+1}, with ready_4 = out_ready.
  - in_ready = ready_1.
  - Latency is 3 cycles from accept to out_valid with no stall.
  - Throughput is 1 beat/cycle. Bubbles collapse, so a full stall holds 3 beats.
- Stage 1: complex products p_x = x*w_x for x in a..d.
  - p_re = xr*wr - xi*wi and p_im = xr*wi + xi*wr, each full 2*WIDTH+1 bits.
  - inverse and scale_sh are registered alongside the products.
- Stage 2: per component, add 2^(WIDTH-2), arithmetic shift right by WIDTH-1 (round half up), then saturate to WIDTH.
  - Example: -32768*-32768 saturates to 32767 and sets sat.
- Stage 3: radix-4 in WIDTH+2 bits.
  - Forward:
    - X0 = A+B+C+D;
    - X1 = A - jB - C + jD;
    - X2 = A - B + C - D;
    - X3 = A + jB - C - jD.
  - Inverse: swap the sign of every j term.
  - Scaling: for scale_sh > 0, add 2^(scale_sh-1), then arithmetic shift right by scale_sh.
  - Saturate to WIDTH, then register into out0..out3.
- scale_sh > MAX_SHIFT is treated as MAX_SHIFT.
- sat:
  - set when any stage-2 or stage-3 saturation occurs on a beat that advances;
  - sat_clr and a saturation event in the same cycle: sat stays 1 (set wins).
- Simultaneous output retire and input accept with full pipeline: allowed, and throughput is held.
- rst mid-operation: in-flight beats are discarded; no partial output is emitted after release.

Decomposition:
- Package fft_pkg holds:
  - the cplx_t struct {re, im} parametrised by WIDTH;
  - twiddle constants W0_4 = {32767,0}, W1_4 = {0,-32768}, W2_4 = {-32768,0};
  - sat_add and round_shift functions.
- Sub-module cmul_q15: complex multiply plus round/saturate, stage-1/2 registers inside. Instantiated 4 times and shares the stage enables.

Test Plan:
1. Forward, scale 0, w=W0_4 on all inputs, a..d = (100,0),(150,0),(200,0),(250,0):
   - outputs after 3 cycles: out0=(700,0), out1=(-100,100), out2=(-100,0), out3=(-100,-100); sat=0.
2. Inverse, same inputs as test 1:
   - out0=(700,0), out1=(-100,-100), out2=(-100,0), out3=(-100,100).
3. Twiddle W1_4 on b only:
   - a=c=d=0, b=(150,0), w1=W1_4, forward -> out0=(0,-150), out1=(-150,0), out2=(0,150), out3=(150,0).
4. Saturation:
   - all inputs (32767,0), w=W0_4, scale 0 -> out0=(32767,0), sat=1.
   - same with scale_sh=2 -> out0=(32766,0).
   - sat_clr pulse -> sat=0.
5. Backpressure:
   - out_ready=0, 4 consecutive in_valid beats -> exactly 3 accepted, in_ready=0, out0 held stable.
   - out_ready=1 -> all 4 beats emerge in order, no loss or duplicate.
6. Reset mid-stream:
   - rst asserted with 2 beats in flight -> out_valid=0 and sat=0 immediately.
   - after release, the first output equals the first beat accepted post-reset.
